// File: rtl/fir_controller.sv
// Moore sequencer for the 4-tap FIR datapath: one register-file micro-op per state.
// Optional: define FIR_CTRL_LC_FROM_ERR_EN to let lc leave EIDLE via a coefficient reload.
module fir_controller #(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  dr,
    input  logic                  lc,
    input  logic                  overflow,
    output logic                  cnt_up,
    output logic                  clear,
    output logic                  modwait,
    output logic [2:0]            op,
    output logic [REG_ADDR_W-1:0] src1,
    output logic [REG_ADDR_W-1:0] src2,
    output logic [REG_ADDR_W-1:0] dest,
    output logic                  err
);

    localparam logic [4:0] IDLE   = 5'd0;
    localparam logic [4:0] STORE  = 5'd1;
    localparam logic [4:0] ZERO   = 5'd2;
    localparam logic [4:0] SORT1  = 5'd3;
    localparam logic [4:0] SORT2  = 5'd4;
    localparam logic [4:0] SORT3  = 5'd5;
    localparam logic [4:0] SORT4  = 5'd6;
    localparam logic [4:0] MUL1   = 5'd7;
    localparam logic [4:0] ADD1   = 5'd8;
    localparam logic [4:0] MUL2   = 5'd9;
    localparam logic [4:0] SUB1   = 5'd10;
    localparam logic [4:0] MUL3   = 5'd11;
    localparam logic [4:0] ADD2   = 5'd12;
    localparam logic [4:0] MUL4   = 5'd13;
    localparam logic [4:0] SUB2   = 5'd14;
    localparam logic [4:0] EIDLE  = 5'd15;
    localparam logic [4:0] LOADC0 = 5'd16;
    localparam logic [4:0] WAITC1 = 5'd17;
    localparam logic [4:0] LOADC1 = 5'd18;
    localparam logic [4:0] WAITC2 = 5'd19;
    localparam logic [4:0] LOADC2 = 5'd20;
    localparam logic [4:0] WAITC3 = 5'd21;
    localparam logic [4:0] LOADC3 = 5'd22;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_COPY  = 3'b001;
    localparam logic [2:0] OP_LOAD1 = 3'b010;
    localparam logic [2:0] OP_LOAD2 = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    localparam logic [REG_ADDR_W-1:0] R0  = REG_ADDR_W'(0);
    localparam logic [REG_ADDR_W-1:0] R1  = REG_ADDR_W'(1);
    localparam logic [REG_ADDR_W-1:0] R2  = REG_ADDR_W'(2);
    localparam logic [REG_ADDR_W-1:0] R3  = REG_ADDR_W'(3);
    localparam logic [REG_ADDR_W-1:0] R4  = REG_ADDR_W'(4);
    localparam logic [REG_ADDR_W-1:0] R5  = REG_ADDR_W'(5);
    localparam logic [REG_ADDR_W-1:0] R6  = REG_ADDR_W'(6);
    localparam logic [REG_ADDR_W-1:0] R7  = REG_ADDR_W'(7);
    localparam logic [REG_ADDR_W-1:0] R8  = REG_ADDR_W'(8);
    localparam logic [REG_ADDR_W-1:0] R9  = REG_ADDR_W'(9);
    localparam logic [REG_ADDR_W-1:0] R10 = REG_ADDR_W'(10);

    logic [4:0] state;
    logic [4:0] next_state;
    logic       next_busy;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            modwait <= 1'b0;
        end else begin
            state   <= next_state;
            modwait <= next_busy;
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                if (dr)      next_state = STORE;
                else if (lc) next_state = LOADC0;
                else         next_state = IDLE;
            end
            STORE:  next_state = dr ? ZERO : EIDLE;
            ZERO:   next_state = SORT1;
            SORT1:  next_state = SORT2;
            SORT2:  next_state = SORT3;
            SORT3:  next_state = SORT4;
            SORT4:  next_state = MUL1;
            MUL1:   next_state = ADD1;
            ADD1:   next_state = overflow ? EIDLE : MUL2;
            MUL2:   next_state = SUB1;
            SUB1:   next_state = overflow ? EIDLE : MUL3;
            MUL3:   next_state = ADD2;
            ADD2:   next_state = overflow ? EIDLE : MUL4;
            MUL4:   next_state = SUB2;
            SUB2:   next_state = overflow ? EIDLE : IDLE;
            EIDLE: begin
                if (dr) next_state = STORE;
`ifdef FIR_CTRL_LC_FROM_ERR_EN
                else if (lc) next_state = LOADC0;
`endif
                else next_state = EIDLE;
            end
            LOADC0: next_state = WAITC1;
            WAITC1: next_state = lc ? LOADC1 : WAITC1;
            LOADC1: next_state = WAITC2;
            WAITC2: next_state = lc ? LOADC2 : WAITC2;
            LOADC2: next_state = WAITC3;
            WAITC3: next_state = lc ? LOADC3 : WAITC3;
            LOADC3: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Busy is registered from the next state so it tracks the state register without a decode glitch.
    always_comb begin
        case (next_state)
            IDLE, EIDLE, WAITC1, WAITC2, WAITC3: next_busy = 1'b0;
            default:                             next_busy = 1'b1;
        endcase
    end

    always_comb begin
        op     = OP_NOP;
        src1   = R0;
        src2   = R0;
        dest   = R0;
        cnt_up = 1'b0;
        clear  = 1'b0;
        err    = 1'b0;
        case (state)
            STORE: begin
                op     = OP_LOAD1;
                dest   = R5;
                cnt_up = 1'b1;
            end
            ZERO:  begin op = OP_SUB;  src1 = R0; src2 = R0;  dest = R0;  end
            SORT1: begin op = OP_COPY; src1 = R2; dest = R1;              end
            SORT2: begin op = OP_COPY; src1 = R3; dest = R2;              end
            SORT3: begin op = OP_COPY; src1 = R4; dest = R3;              end
            SORT4: begin op = OP_COPY; src1 = R5; dest = R4;              end
            MUL1:  begin op = OP_MUL;  src1 = R1; src2 = R6;  dest = R10; end
            ADD1:  begin op = OP_ADD;  src1 = R0; src2 = R10; dest = R0;  end
            MUL2:  begin op = OP_MUL;  src1 = R2; src2 = R7;  dest = R10; end
            SUB1:  begin op = OP_SUB;  src1 = R0; src2 = R10; dest = R0;  end
            MUL3:  begin op = OP_MUL;  src1 = R3; src2 = R8;  dest = R10; end
            ADD2:  begin op = OP_ADD;  src1 = R0; src2 = R10; dest = R0;  end
            MUL4:  begin op = OP_MUL;  src1 = R4; src2 = R9;  dest = R10; end
            SUB2:  begin op = OP_SUB;  src1 = R0; src2 = R10; dest = R0;  end
            EIDLE: err = 1'b1;
            LOADC0: begin
                op    = OP_LOAD2;
                dest  = R6;
                clear = 1'b1;
            end
            LOADC1: begin op = OP_LOAD2; dest = R7; end
            LOADC2: begin op = OP_LOAD2; dest = R8; end
            LOADC3: begin op = OP_LOAD2; dest = R9; end
            default: begin end
        endcase
    end

endmodule

// File: tb/tb_fir_controller.sv
// Directed bench for fir_controller: coefficient load, sample sequence, error and reset paths.
module tb_fir_controller;

    logic       clk;
    logic       n_rst;
    logic       dr;
    logic       lc;
    logic       overflow;
    logic       cnt_up;
    logic       clear;
    logic       modwait;
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
    logic       err;

    int tests_run;
    int tests_failed;

    // {0,op, src1, src2, dest} per busy state, STORE first through SUB2.
    logic [15:0] seq_exp [14];

    fir_controller #(.REG_ADDR_W(4)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .dr       (dr),
        .lc       (lc),
        .overflow (overflow),
        .cnt_up   (cnt_up),
        .clear    (clear),
        .modwait  (modwait),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .dest     (dest),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_err);
        check({tag, " op"}, 32'(op), 32'd0);
        check({tag, " modwait"}, 32'(modwait), 32'd0);
        check({tag, " err"}, 32'(err), 32'(exp_err));
        check({tag, " strobes"}, {30'd0, cnt_up, clear}, 32'd0);
    endtask

    // One coefficient pulse followed by a 3-cycle gap.
    task automatic load_coef(input int idx);
        lc = 1'b1;
        tick();
        lc = 1'b0;
        check($sformatf("coef%0d op", idx), 32'(op), 32'd3);
        check($sformatf("coef%0d dest", idx), 32'(dest), 32'(6 + idx));
        check($sformatf("coef%0d clear", idx), 32'(clear), 32'(idx == 0));
        check($sformatf("coef%0d modwait", idx), 32'(modwait), 32'd1);
        for (int g = 0; g < 3; g++) begin
            tick();
            check($sformatf("coef%0d gap", idx), {28'd0, op, modwait}, 32'd0);
        end
    endtask

    // Runs a sample from IDLE/EIDLE; overflow is raised in the state at index ovf_at.
    task automatic run_sample(input string tag, input int ovf_at);
        int nup;
        int nbusy;
        bit aborted;
        nup = 0;
        nbusy = 0;
        aborted = 1'b0;
        dr = 1'b1;
        tick();
        for (int i = 0; i < 14 && !aborted; i++) begin
            check($sformatf("%s step%0d uop", tag, i), {16'd0, 1'b0, op, src1, src2, dest}, 32'(seq_exp[i]));
            check($sformatf("%s step%0d err", tag, i), 32'(err), 32'd0);
            check($sformatf("%s step%0d clear", tag, i), 32'(clear), 32'd0);
            nup += int'(cnt_up);
            nbusy += int'(modwait);
            if (i == 1) dr = 1'b0;
            overflow = (i == ovf_at);
            tick();
            overflow = 1'b0;
            if (i == ovf_at && (i == 7 || i == 9 || i == 11 || i == 13)) begin
                aborted = 1'b1;
                check({tag, " ovf err"}, 32'(err), 32'd1);
                check({tag, " ovf modwait"}, 32'(modwait), 32'd0);
                check({tag, " ovf op"}, 32'(op), 32'd0);
            end
        end
        if (!aborted) begin
            check({tag, " cnt_up count"}, 32'(nup), 32'd1);
            check({tag, " busy count"}, 32'(nbusy), 32'd14);
            check_idle({tag, " end"}, 1'b0);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        seq_exp = '{16'h2005, 16'h5000, 16'h1201, 16'h1302, 16'h1403, 16'h1504, 16'h616A,
                    16'h40A0, 16'h627A, 16'h50A0, 16'h638A, 16'h40A0, 16'h649A, 16'h50A0};
        n_rst = 1'b0;
        dr = 1'b0;
        lc = 1'b0;
        overflow = 1'b0;
        #1;
        check_idle("reset", 1'b0);
        check("reset regs", {20'd0, src1, src2, dest}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        check_idle("post reset", 1'b0);

        for (int k = 0; k < 4; k++) load_coef(k);
        check_idle("coef end", 1'b0);

        run_sample("sample", -1);

        // dr held for one cycle only
        dr = 1'b1;
        tick();
        dr = 1'b0;
        check("drop store op", 32'(op), 32'd2);
        check("drop cnt_up", 32'(cnt_up), 32'd1);
        tick();
        check_idle("drop eidle", 1'b1);
        tick();
        check_idle("drop eidle hold", 1'b1);
        run_sample("recover", -1);

        run_sample("ovf sub1", 9);
        lc = 1'b1;
        tick();
        lc = 1'b0;
`ifdef FIR_CTRL_LC_FROM_ERR_EN
        check("err lc op", 32'(op), 32'd3);
        check("err lc clear", 32'(clear), 32'd1);
        check("err lc err", 32'(err), 32'd0);
        for (int g = 0; g < 3; g++) tick();
        for (int k = 1; k < 4; k++) load_coef(k);
        check_idle("err lc end", 1'b0);
`else
        check_idle("err lc ignored", 1'b1);
`endif
        run_sample("ovf mul3", 10);

        // dr wins over lc in IDLE
        dr = 1'b1;
        lc = 1'b1;
        tick();
        lc = 1'b0;
        check("prio op", 32'(op), 32'd2);
        check("prio clear", 32'(clear), 32'd0);
        tick();
        dr = 1'b0;
        for (int t = 0; t < 7; t++) tick();
        check("pre reset mul2", {16'd0, 1'b0, op, src1, src2, dest}, 32'h627A);
        #2;
        n_rst = 1'b0;
        #1;
        check_idle("async reset", 1'b0);
        check("async reset regs", {20'd0, src1, src2, dest}, 32'd0);
        n_rst = 1'b1;
        tick();
        check_idle("after reset", 1'b0);
        tick();
        check_idle("after reset hold", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
